// File: rtl/uart_pkg.sv
// Shared constants for the uart FIFO bridge: host register map, control and
// status bit positions, and the uart-side master FSM state encoding.
package uart_pkg;

  // Host register addresses
  localparam logic UART_ADR_DATA = 1'b0;
  localparam logic UART_ADR_CTRL = 1'b1;

  // Control register (write) bit positions
  localparam int CTRL_TX_FLUSH = 0;
  localparam int CTRL_RX_FLUSH = 1;
  localparam int CTRL_IRQ_EN   = 24;

  // Status register (read) bit positions
  localparam int ST_TX_CNT_LSB = 0;
  localparam int ST_RX_CNT_LSB = 8;
  localparam int ST_TX_FULL    = 16;
  localparam int ST_RX_EMPTY   = 17;
  localparam int ST_IRQ_EN     = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with flush. Head is combinational from storage; full/empty
// derive from the registered count, so they only move on a clock edge.
// Ports: clk, rst (async high), push/pop/flush, din, head, full, empty,
// count (0..DEPTH).
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int LOG   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LOG:0]     count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LOG-1:0]   wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (LOG+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Host-facing Avalon-MM slave with TX/RX byte FIFOs in front of a single-byte
// uart. The uart side is an Avalon-MM master that drains TX into uart writes
// and pulls received bytes into RX whenever the uart flags one.
// Ports: host_* slave (addr 0 data, addr 1 ctrl/status), host_irq (RX not
// empty, gated by irq_en), uart_* master plus uart_status_irq/err inputs.
module uart_fifo_bridge
  import uart_pkg::*;
#(
  parameter int ADW      = 32,
  parameter int BYTESIZE = 8,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16,
  parameter int TX_LOG   = $clog2(TX_DEPTH),
  parameter int RX_LOG   = $clog2(RX_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           host_address,
  input  logic           host_read,
  input  logic           host_write,
  input  logic [ADW-1:0] host_writedata,
  output logic [ADW-1:0] host_readdata,
  output logic           host_waitrequest,
  output logic           host_irq,
  output logic           uart_read,
  output logic           uart_write,
  output logic [ADW-1:0] uart_writedata,
  input  logic [ADW-1:0] uart_readdata,
  input  logic           uart_waitrequest,
  input  logic           uart_status_irq,
  input  logic           uart_status_err
);

  fsm_state_t state, state_nxt;

  logic                tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic                rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [BYTESIZE-1:0] tx_head;
  logic [BYTESIZE+1:0] rx_head, rx_din;
  logic [TX_LOG:0]     tx_count;
  logic [RX_LOG:0]     rx_count;
  logic                irq_en;
  logic                ctrl_wr;
  logic                rx_want;
  logic                unused_bits;

  assign unused_bits = ^{host_writedata, uart_readdata, uart_status_err};

  assign ctrl_wr  = host_write & (host_address == UART_ADR_CTRL);
  assign tx_flush = ctrl_wr & host_writedata[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & host_writedata[CTRL_RX_FLUSH];

  // Stall decision uses the registered full flag, so a same-cycle uart pop
  // does not open space for the host.
  assign host_waitrequest = host_write & (host_address == UART_ADR_DATA) & tx_full;
  assign tx_push = host_write & (host_address == UART_ADR_DATA) & ~tx_full;
  assign rx_pop  = host_read & (host_address == UART_ADR_DATA) & ~rx_empty;

  // {err, parity, data}; err sits just below the uart's irq bit.
  assign rx_din  = {uart_readdata[ADW-2], uart_readdata[BYTESIZE], uart_readdata[BYTESIZE-1:0]};
  assign rx_want = uart_status_irq & ~rx_full;

  uart_fifo #(.WIDTH(BYTESIZE), .DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
    .din(host_writedata[BYTESIZE-1:0]), .head(tx_head),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  uart_fifo #(.WIDTH(BYTESIZE+2), .DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .flush(rx_flush),
    .din(rx_din), .head(rx_head),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en   <= 1'b0;
      host_irq <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= host_writedata[CTRL_IRQ_EN];
      host_irq <= irq_en & ~rx_empty;
    end
  end

  always_comb begin
    host_readdata = '0;
    if (host_address == UART_ADR_DATA) begin
      if (!rx_empty) begin
        host_readdata[ADW-1]        = 1'b1;
        host_readdata[BYTESIZE+1:0] = rx_head;
      end
    end else begin
      host_readdata[ST_IRQ_EN]                    = irq_en;
      host_readdata[ST_RX_EMPTY]                  = rx_empty;
      host_readdata[ST_TX_FULL]                   = tx_full;
      host_readdata[ST_RX_CNT_LSB +: 8]           = 8'(rx_count);
      host_readdata[ST_TX_CNT_LSB +: 8]           = 8'(tx_count);
    end
  end

  always_comb begin
    uart_writedata                 = '0;
    uart_writedata[BYTESIZE-1:0]   = tx_head;
  end

  // Master FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Master FSM: next state. A pending RX byte beats TX so the uart's single
  // byte buffer is emptied before it can overrun.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rx_want)        state_nxt = ST_READ;
        else if (!tx_empty) state_nxt = ST_WRITE;
      end
      ST_READ:              state_nxt = ST_IDLE;
      ST_WRITE: begin
        if (tx_flush || !uart_waitrequest) state_nxt = ST_IDLE;
        else if (rx_want)                  state_nxt = ST_READ;
      end
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Master FSM: outputs. A flush drops the in-flight write outright.
  always_comb begin
    uart_read  = (state == ST_READ);
    uart_write = (state == ST_WRITE) & ~tx_flush;
    tx_pop     = (state == ST_WRITE) & ~tx_flush & ~uart_waitrequest;
    rx_push    = (state == ST_READ);
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
module tb_uart_fifo_bridge;
  localparam int ADW = 32;
  localparam int TXD = 16;
  localparam int RXD = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           host_address, host_read, host_write;
  logic [ADW-1:0] host_writedata, host_readdata;
  logic           host_waitrequest, host_irq;
  logic           uart_read, uart_write;
  logic [ADW-1:0] uart_writedata, uart_readdata;
  logic           uart_waitrequest, uart_status_irq, uart_status_err;

  uart_fifo_bridge dut (
    .clk(clk), .rst(rst),
    .host_address(host_address), .host_read(host_read), .host_write(host_write),
    .host_writedata(host_writedata), .host_readdata(host_readdata),
    .host_waitrequest(host_waitrequest), .host_irq(host_irq),
    .uart_read(uart_read), .uart_write(uart_write), .uart_writedata(uart_writedata),
    .uart_readdata(uart_readdata), .uart_waitrequest(uart_waitrequest),
    .uart_status_irq(uart_status_irq), .uart_status_err(uart_status_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] tx_q[$];
  logic [9:0] rx_q[$];
  logic [7:0] wr_log[$];
  bit         m_irq_en, m_irq;
  int         n_uread = 0;

  function automatic logic [31:0] status_word();
    logic [31:0] s;
    s = '0;
    s[24]   = m_irq_en;
    s[17]   = (rx_q.size() == 0);
    s[16]   = (tx_q.size() == TXD);
    s[15:8] = 8'(rx_q.size());
    s[7:0]  = 8'(tx_q.size());
    return s;
  endfunction

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    bit fl_tx, fl_rx, tx_was_full, nxt_irq;
    if (rst) begin
      tx_q.delete(); rx_q.delete();
      m_irq_en = 0; m_irq = 0;
      chk("rst_uart_write", {31'b0, uart_write}, 0);
      chk("rst_uart_read", {31'b0, uart_read}, 0);
      chk("rst_host_irq", {31'b0, host_irq}, 0);
      chk("rst_waitreq", {31'b0, host_waitrequest}, 0);
    end else begin
      tx_was_full = (tx_q.size() == TXD);
      chk("waitreq", {31'b0, host_waitrequest},
          {31'b0, host_write && !host_address && tx_was_full});
      chk("host_irq", {31'b0, host_irq}, {31'b0, m_irq});
      if (host_address) exp_rd = status_word();
      else if (rx_q.size() != 0) exp_rd = {1'b1, 21'b0, rx_q[0]};
      else exp_rd = '0;
      chk("readdata", host_readdata, exp_rd);
      if (uart_read && uart_write) chk("rd_wr_overlap", 1, 0);
      if (uart_write) begin
        if (tx_q.size() == 0) chk("write_from_empty", 1, 0);
        else chk("uart_writedata", uart_writedata, {24'b0, tx_q[0]});
      end
      if (uart_read) chk("read_while_rx_full", {31'b0, rx_q.size() == RXD}, 0);

      // advance model to the next edge
      fl_tx   = host_write && host_address && host_writedata[0];
      fl_rx   = host_write && host_address && host_writedata[1];
      nxt_irq = m_irq_en && (rx_q.size() != 0);
      if (host_read && !host_address && rx_q.size() != 0) void'(rx_q.pop_front());
      if (uart_read) begin
        n_uread++;
        rx_q.push_back({uart_readdata[30], uart_readdata[8], uart_readdata[7:0]});
      end
      if (uart_write && !uart_waitrequest) begin
        wr_log.push_back(uart_writedata[7:0]);
        if (tx_q.size() != 0) void'(tx_q.pop_front());
      end
      if (host_write && !host_address && !tx_was_full) tx_q.push_back(host_writedata[7:0]);
      if (host_write && host_address) m_irq_en = host_writedata[24];
      if (fl_tx) tx_q.delete();
      if (fl_rx) rx_q.delete();
      m_irq = nxt_irq;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic hwr(input logic a, input logic [31:0] d);
    bit done;
    host_address = a; host_writedata = d; host_write = 1'b1;
    done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!host_waitrequest) begin done = 1; break; end
    end
    if (!done) chk("host_write_timeout", 1, 0);
    cyc();
    host_write = 1'b0;
  endtask

  task automatic hrd(input logic a, output logic [31:0] d);
    host_address = a; host_read = 1'b1;
    @(negedge clk);
    d = host_readdata;
    cyc();
    host_read = 1'b0;
  endtask

  // uart stub: present a byte and hold status_irq until the bridge reads it
  task automatic ugive(input logic [31:0] d, output bit got);
    uart_readdata = d; uart_status_irq = 1'b1; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uart_read) begin got = 1; break; end
    end
    cyc();
    if (got) uart_status_irq = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    bit got;
    int n0;
    rst = 1'b1; host_address = 0; host_read = 0; host_write = 0; host_writedata = '0;
    uart_readdata = '0; uart_waitrequest = 1'b1; uart_status_irq = 0; uart_status_err = 0;
    repeat (3) @(posedge clk);
    #1 host_address = 1; host_read = 1;
    #1 chk("reset_status", host_readdata, 32'h0002_0000);
    host_read = 0; rst = 1'b0;
    cyc();

    // TX burst with 20-cycle stalls per byte
    hwr(0, 32'h55); hwr(0, 32'hA3); hwr(0, 32'h0F);
    for (int k = 0; k < 3; k++) begin
      repeat (20) cyc();
      uart_waitrequest = 1'b0; cyc(); uart_waitrequest = 1'b1;
    end
    chk("burst_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("burst_b0", {24'b0, wr_log[0]}, 32'h55);
      chk("burst_b1", {24'b0, wr_log[1]}, 32'hA3);
      chk("burst_b2", {24'b0, wr_log[2]}, 32'h0F);
    end
    hrd(1, d); chk("burst_status", d, 32'h0002_0000);

    // RX path
    hwr(1, 32'h0100_0000);
    n0 = n_uread;
    ugive(32'h0000_01C4, got);
    chk("rx_got_read", {31'b0, got}, 1);
    repeat (3) cyc();
    chk("rx_one_read", n_uread - n0, 1);
    chk("rx_host_irq", {31'b0, host_irq}, 1);
    hrd(0, d); chk("rx_read1", d, 32'h8000_01C4);
    hrd(0, d); chk("rx_read2", d, 32'h0000_0000);

    // RX priority over a stalled write
    hwr(0, 32'h3C);
    repeat (5) cyc();
    chk("prio_writing", {31'b0, uart_write}, 1);
    n0 = wr_log.size();
    ugive(32'h0000_0011, got);
    chk("prio_got_read", {31'b0, got}, 1);
    chk("prio_no_write_yet", wr_log.size(), n0);
    uart_waitrequest = 1'b0; repeat (5) cyc(); uart_waitrequest = 1'b1;
    chk("prio_one_write", wr_log.size(), n0 + 1);
    if (wr_log.size() == n0 + 1) chk("prio_byte", {24'b0, wr_log[n0]}, 32'h3C);
    hrd(0, d); chk("prio_rx", d, 32'h8000_0011);

    // TX full and flush
    for (int i = 0; i < TXD; i++) hwr(0, 32'(8'h80 + i));
    hrd(1, d); chk("tx_full_status", d, 32'h0103_0010);
    host_address = 0; host_writedata = 32'hEE; host_write = 1'b1;
    @(negedge clk); chk("tx_17th_stalls", {31'b0, host_waitrequest}, 1);
    cyc(); host_write = 1'b0;
    hwr(1, 32'h0100_0001);
    hrd(1, d); chk("flush_full_status", d, 32'h0102_0000);
    n0 = wr_log.size();
    uart_waitrequest = 1'b0; repeat (10) cyc(); uart_waitrequest = 1'b1;
    chk("flush_full_nowrite", wr_log.size(), n0);
    for (int i = 0; i < 5; i++) hwr(0, 32'(8'h20 + i));
    hrd(1, d); chk("five_status", d, 32'h0102_0005);
    hwr(1, 32'h0100_0001);
    hrd(1, d); chk("flush5_status", d, 32'h0102_0000);
    uart_waitrequest = 1'b0; repeat (10) cyc(); uart_waitrequest = 1'b1;
    chk("flush5_nowrite", wr_log.size(), n0);

    // RX full
    for (int i = 0; i < RXD; i++) begin
      b = 8'(8'h40 + i);
      ugive({23'b0, 1'(i & 1), b}, got);
      chk("rxfill_read", {31'b0, got}, 1);
    end
    n0 = n_uread;
    ugive(32'h0000_00AA, got);
    chk("rxfull_no_read", {31'b0, got}, 0);
    chk("rxfull_no_read_cnt", n_uread - n0, 0);
    hrd(1, d); chk("rxfull_status", d, 32'h0100_1000);
    uart_status_irq = 1'b0;
    for (int i = 0; i < RXD; i++) begin
      hrd(0, d);
      b = 8'(8'h40 + i);
      chk("rxdrain", d, {1'b1, 22'b0, 1'(i & 1), b});
    end
    hrd(1, d); chk("rxdrain_status", d, 32'h0102_0000);

    // reset in the middle of a stalled write, with host_irq up
    ugive(32'h0000_0077, got);
    repeat (3) cyc();
    chk("pre_rst_irq", {31'b0, host_irq}, 1);
    hwr(0, 32'h99);
    repeat (3) cyc();
    chk("pre_rst_write", {31'b0, uart_write}, 1);
    host_address = 1; host_read = 1; rst = 1'b1;
    #1;
    chk("rst_mid_write", {31'b0, uart_write}, 0);
    chk("rst_mid_irq", {31'b0, host_irq}, 0);
    chk("rst_mid_status", host_readdata, 32'h0002_0000);
    cyc(); rst = 1'b0; host_read = 0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule
